// File: rtl/lock_actuator_driver_if.sv
// ----------------------------------------------------------------------------
// lock_actuator_driver_if
//
// Purpose:
//   Groups the command pulses coming from the lock control FSM and the timed
//   drive signals going out to the board pins into a single bundle.
//
// Signals:
//   open_req   1-cycle pulse: unlock request            (controller -> driver)
//   lock_req   1-cycle pulse: re-lock request           (controller -> driver)
//   alarm_req  1-cycle pulse: alarm burst request       (controller -> driver)
//   solenoid   solenoid drive, high while energizing    (driver -> pins)
//   unlocked   high while the door is unlocked          (driver -> pins)
//   buzzer     buzzer drive                             (driver -> pins)
//   busy       high whenever the driver is not LOCKED   (driver -> controller)
//
// Modports:
//   master  the side that issues commands and observes the drive signals
//   slave   the lock_actuator_driver itself
// ----------------------------------------------------------------------------
interface lock_actuator_driver_if;

    logic open_req;
    logic lock_req;
    logic alarm_req;
    logic solenoid;
    logic unlocked;
    logic buzzer;
    logic busy;

    modport master (
        output open_req,
        output lock_req,
        output alarm_req,
        input  solenoid,
        input  unlocked,
        input  buzzer,
        input  busy
    );

    modport slave (
        input  open_req,
        input  lock_req,
        input  alarm_req,
        output solenoid,
        output unlocked,
        output buzzer,
        output busy
    );

endinterface

// File: rtl/lock_actuator_driver.sv
// ----------------------------------------------------------------------------
// lock_actuator_driver
//
// Purpose:
//   Output side of the lock. Turns single-cycle command pulses into timed
//   physical drive signals: a bounded solenoid energize pulse, an unlocked
//   window that re-locks automatically, and a buzzer that beeps on every
//   unlock / retrigger (plus an optional alarm burst).
//
// Parameters:
//   OPEN_CYCLES       cycles the solenoid is energized per unlock (>=1)
//   AUTO_LOCK_CYCLES  cycles spent in OPEN before automatic re-lock (>=1)
//   BEEP_CYCLES       buzzer on-time per beep; also alarm off-time (>=1)
//   ALARM_BEEPS       beeps per alarm burst (only used with ALARM_EN)
//   CNT_W             counter width, must hold every cycle parameter
//
// Ports:
//   clk    in   system clock, all logic on the rising edge
//   rst_n  in   asynchronous reset, active low
//   bus    slave modport of lock_actuator_driver_if
//            open_req/lock_req/alarm_req in, solenoid/unlocked/buzzer/busy out
//
// Configuration macro:
//   ALARM_EN  when defined, alarm_req starts a burst of ALARM_BEEPS beeps
//             (BEEP_CYCLES on, BEEP_CYCLES off) that overrides open beeps.
//             When undefined, alarm_req is ignored and no alarm logic exists.
// ----------------------------------------------------------------------------
module lock_actuator_driver #(
    parameter int OPEN_CYCLES      = 50,
    parameter int AUTO_LOCK_CYCLES = 500,
    parameter int BEEP_CYCLES      = 10,
    parameter int ALARM_BEEPS      = 4,
    parameter int CNT_W            = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lock_actuator_driver_if.slave   bus
);

    // ------------------------------------------------------------------
    // Elaboration-time sanity check of the configuration
    // ------------------------------------------------------------------
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if ((OPEN_CYCLES < 1) || (AUTO_LOCK_CYCLES < 1) || (BEEP_CYCLES < 1) ||
        (ALARM_BEEPS < 1) || (OPEN_CYCLES > CNT_MAX) ||
        (AUTO_LOCK_CYCLES > CNT_MAX) || (BEEP_CYCLES > CNT_MAX) ||
        (ALARM_BEEPS > CNT_MAX)) begin : gBadConfig
        $error("lock_actuator_driver: cycle parameters must be >=1 and fit in CNT_W bits");
    end

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_LOCKED = 2'd0;
    localparam logic [1:0] ST_PULSE  = 2'd1;
    localparam logic [1:0] ST_OPEN   = 2'd2;

    // Terminal counts: counters run 0..N-1 so an N-cycle interval ends on N-1
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             beepOn_q,   beepOn_d;
    logic [CNT_W-1:0] beepCnt_q,  beepCnt_d;
    logic             beepStart;

    logic             solenoid_q, solenoid_d;
    logic             unlocked_q, unlocked_d;
    logic             busy_q,     busy_d;
    logic             buzzer_q,   buzzer_d;

    // ------------------------------------------------------------------
    // Main FSM. cnt_q times the current state and is cleared on every
    // state change. In OPEN, lock_req has priority over open_req; an
    // open_req there only restarts the window and the beep, the solenoid
    // is not pulsed again.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beepStart = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (bus.open_req) begin
                    state_d   = ST_PULSE;
                    cnt_d     = CNT_ZERO;
                    beepStart = 1'b1;
                end
            end

            ST_PULSE: begin
                if (cnt_q == OPEN_LAST) begin
                    state_d = ST_OPEN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_OPEN: begin
                if (bus.lock_req) begin
                    state_d = ST_LOCKED;
                    cnt_d   = CNT_ZERO;
                end else if (bus.open_req) begin
                    cnt_d     = CNT_ZERO;
                    beepStart = 1'b1;
                end else if (cnt_q == AUTO_LAST) begin
                    state_d = ST_LOCKED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_LOCKED;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Open beep. A start (unlock or retrigger) reloads the counter even if
    // a beep is already running, so the buzzer stays high without a gap
    // for a full BEEP_CYCLES from the latest start.
    // ------------------------------------------------------------------
    always_comb begin
        beepOn_d  = beepOn_q;
        beepCnt_d = beepCnt_q;

        if (beepStart) begin
            beepOn_d  = 1'b1;
            beepCnt_d = CNT_ZERO;
        end else if (beepOn_q) begin
            if (beepCnt_q == BEEP_LAST) begin
                beepOn_d  = 1'b0;
                beepCnt_d = CNT_ZERO;
            end else begin
                beepCnt_d = beepCnt_q + CNT_ONE;
            end
        end
    end

`ifdef ALARM_EN
    // ------------------------------------------------------------------
    // Alarm burst: ALARM_BEEPS repetitions of BEEP_CYCLES on followed by
    // BEEP_CYCLES off. alarmPhase_q times the current half-period,
    // alarmGap_q marks the off half, alarmIdx_q counts completed beeps.
    // A new alarm_req restarts the burst from its first on-phase. The
    // burst runs independently of the lock state.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_BEEPS - 1);

    logic             alarmOn_q,    alarmOn_d;
    logic             alarmGap_q,   alarmGap_d;
    logic [CNT_W-1:0] alarmPhase_q, alarmPhase_d;
    logic [CNT_W-1:0] alarmIdx_q,   alarmIdx_d;

    always_comb begin
        alarmOn_d    = alarmOn_q;
        alarmGap_d   = alarmGap_q;
        alarmPhase_d = alarmPhase_q;
        alarmIdx_d   = alarmIdx_q;

        if (bus.alarm_req) begin
            alarmOn_d    = 1'b1;
            alarmGap_d   = 1'b0;
            alarmPhase_d = CNT_ZERO;
            alarmIdx_d   = CNT_ZERO;
        end else if (alarmOn_q) begin
            if (alarmPhase_q == BEEP_LAST) begin
                alarmPhase_d = CNT_ZERO;
                if (!alarmGap_q) begin
                    alarmGap_d = 1'b1;
                end else if (alarmIdx_q == ALARM_LAST) begin
                    alarmOn_d  = 1'b0;
                    alarmGap_d = 1'b0;
                    alarmIdx_d = CNT_ZERO;
                end else begin
                    alarmGap_d = 1'b0;
                    alarmIdx_d = alarmIdx_q + CNT_ONE;
                end
            end else begin
                alarmPhase_d = alarmPhase_q + CNT_ONE;
            end
        end
    end

    // Alarm registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarmOn_q    <= 1'b0;
            alarmGap_q   <= 1'b0;
            alarmPhase_q <= CNT_ZERO;
            alarmIdx_q   <= CNT_ZERO;
        end else begin
            alarmOn_q    <= alarmOn_d;
            alarmGap_q   <= alarmGap_d;
            alarmPhase_q <= alarmPhase_d;
            alarmIdx_q   <= alarmIdx_d;
        end
    end

    // While a burst is active it owns the buzzer
    assign buzzer_d = alarmOn_d ? !alarmGap_d : beepOn_d;
`else
    assign buzzer_d = beepOn_d;
`endif

    // ------------------------------------------------------------------
    // Outputs are decoded from the next state so that the registered pins
    // change on the same edge as the state itself (1-cycle latency from a
    // request pulse).
    // ------------------------------------------------------------------
    assign solenoid_d = (state_d == ST_PULSE);
    assign unlocked_d = (state_d != ST_LOCKED);
    assign busy_d     = (state_d != ST_LOCKED);

    // State, counters and registered outputs; reset de-energizes at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKED;
            cnt_q      <= CNT_ZERO;
            beepOn_q   <= 1'b0;
            beepCnt_q  <= CNT_ZERO;
            solenoid_q <= 1'b0;
            unlocked_q <= 1'b0;
            busy_q     <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beepOn_q   <= beepOn_d;
            beepCnt_q  <= beepCnt_d;
            solenoid_q <= solenoid_d;
            unlocked_q <= unlocked_d;
            busy_q     <= busy_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign bus.solenoid = solenoid_q;
    assign bus.unlocked = unlocked_q;
    assign bus.busy     = busy_q;
    assign bus.buzzer   = buzzer_q;

endmodule

// File: tb/tb_lock_actuator_driver.sv
// ----------------------------------------------------------------------------
// tb_lock_actuator_driver
//
// Purpose:
//   Self-checking bench for lock_actuator_driver with OPEN_CYCLES=4,
//   AUTO_LOCK_CYCLES=10, BEEP_CYCLES=2, ALARM_BEEPS=2. A behavioural model
//   built on remaining-time counters predicts the outputs after every clock
//   edge; predictions are queued and compared at the following falling edge.
//   Honours the ALARM_EN macro the same way as the design.
// ----------------------------------------------------------------------------
module tb_lock_actuator_driver;

    localparam int OC = 4;
    localparam int AC = 10;
    localparam int BC = 2;
    localparam int AB = 2;

`ifdef ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;

    lock_actuator_driver_if bus ();

    lock_actuator_driver #(
        .OPEN_CYCLES      (OC),
        .AUTO_LOCK_CYCLES (AC),
        .BEEP_CYCLES      (BC),
        .ALARM_BEEPS      (AB),
        .CNT_W            (13)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic sol;
        logic unl;
        logic buz;
        logic bsy;
    } exp_t;

    exp_t expQ[$];

    int checkCount = 0;
    int errorCount = 0;

    // Model: 0 LOCKED, 1 PULSE, 2 OPEN; mRemain = cycles left in state
    int mState;
    int mRemain;
    int mBeep;
    int mAlarmPos;

    // Observed high-cycle tallies for per-test duration checks
    int solCycles;
    int unlCycles;
    int buzCycles;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState    = 0;
        mRemain   = 0;
        mBeep     = 0;
        mAlarmPos = -1;
        expQ.delete();
    endtask

    // Advance the model by one clock edge and queue the predicted outputs
    task automatic modelStep(input logic o, input logic l, input logic a);
        exp_t e;
        if (mBeep > 0) mBeep--;
        case (mState)
            0: if (o) begin
                mState  = 1;
                mRemain = OC;
                mBeep   = BC;
            end
            1: if (mRemain == 1) begin
                mState  = 2;
                mRemain = AC;
            end else begin
                mRemain--;
            end
            default: if (l) begin
                mState = 0;
            end else if (o) begin
                mRemain = AC;
                mBeep   = BC;
            end else if (mRemain == 1) begin
                mState = 0;
            end else begin
                mRemain--;
            end
        endcase
        if (ALARM_ON && a) begin
            mAlarmPos = 0;
        end else if (mAlarmPos >= 0) begin
            mAlarmPos++;
            if (mAlarmPos == 2 * BC * AB) mAlarmPos = -1;
        end
        e.sol = (mState == 1);
        e.unl = (mState != 0);
        e.bsy = (mState != 0);
        e.buz = (mAlarmPos >= 0) ? ((mAlarmPos % (2 * BC)) < BC) : (mBeep > 0);
        expQ.push_back(e);
    endtask

    // Pop one prediction and compare it with the DUT outputs
    task automatic compareStep();
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("queueEmpty", 0, 1);
        end else begin
            e = expQ.pop_front();
            checkOutput("solenoid", int'(bus.solenoid), int'(e.sol));
            checkOutput("unlocked", int'(bus.unlocked), int'(e.unl));
            checkOutput("buzzer",   int'(bus.buzzer),   int'(e.buz));
            checkOutput("busy",     int'(bus.busy),     int'(e.bsy));
        end
        if (bus.solenoid === 1'b1) solCycles++;
        if (bus.unlocked === 1'b1) unlCycles++;
        if (bus.buzzer   === 1'b1) buzCycles++;
    endtask

    // Drive one cycle of command pulses, then check at the falling edge
    task automatic applyStimulus(input logic o, input logic l, input logic a);
        bus.open_req  = o;
        bus.lock_req  = l;
        bus.alarm_req = a;
        @(posedge clk);
        modelStep(o, l, a);
        #1;
        bus.open_req  = 1'b0;
        bus.lock_req  = 1'b0;
        bus.alarm_req = 1'b0;
        @(negedge clk);
        compareStep();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clearTallies();
        solCycles = 0;
        unlCycles = 0;
        buzCycles = 0;
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_solenoid"}, int'(bus.solenoid), 0);
        checkOutput({tag, "_unlocked"}, int'(bus.unlocked), 0);
        checkOutput({tag, "_buzzer"},   int'(bus.buzzer),   0);
        checkOutput({tag, "_busy"},     int'(bus.busy),     0);
    endtask

    initial begin
        bus.open_req  = 1'b0;
        bus.lock_req  = 1'b0;
        bus.alarm_req = 1'b0;
        rst_n         = 1'b0;
        modelReset();
        clearTallies();
        repeat (2) @(negedge clk);
        checkAllLow("reset");
        rst_n = 1'b1;

        // Test 1: plain unlock and automatic re-lock
        $display("[TB] test 1: unlock and auto re-lock");
        clearTallies();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(16);
        checkOutput("t1_solenoidLen", solCycles, OC);
        checkOutput("t1_unlockedLen", unlCycles, OC + AC);
        checkOutput("t1_buzzerLen",   buzCycles, BC);

        // Test 2: manual re-lock 3 cycles into OPEN
        $display("[TB] test 2: lock_req in OPEN");
        clearTallies();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(OC + 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(4);
        checkOutput("t2_solenoidLen", solCycles, OC);
        checkOutput("t2_unlockedLen", unlCycles, OC + 3);

        // Test 3: retrigger 5 cycles into OPEN extends the window by 5
        $display("[TB] test 3: open_req retrigger in OPEN");
        clearTallies();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(OC + 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(AC + 3);
        checkOutput("t3_solenoidLen", solCycles, OC);
        checkOutput("t3_unlockedLen", unlCycles, OC + AC + 5);
        checkOutput("t3_buzzerLen",   buzCycles, 2 * BC);

        // Test 4: open_req in PULSE ignored, then reset mid-PULSE
        $display("[TB] test 4: reset during PULSE");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkAllLow("t4_rstAsync");
        modelReset();
        @(negedge clk);
        checkAllLow("t4_rstHeld");
        rst_n = 1'b1;
        clearTallies();
        idle(4);
        checkOutput("t4_unlockedAfter", unlCycles, 0);

        // Test 5: alarm burst in LOCKED, in OPEN, and restarted mid-burst
        $display("[TB] test 5: alarm bursts");
        clearTallies();
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(10);
        checkOutput("t5_alarmBuzzLen", buzCycles, ALARM_ON ? (AB * BC) : 0);
        checkOutput("t5_alarmUnlocked", unlCycles, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(6);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(18);

        // Test 6: simultaneous open_req and lock_req
        $display("[TB] test 6: open_req with lock_req");
        clearTallies();
        applyStimulus(1'b1, 1'b1, 1'b0);
        idle(OC + 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        idle(3);
        checkOutput("t6_unlockedLen", unlCycles, OC + 2);

        // Random command pulses against the model
        $display("[TB] random command traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 11) == 0),
                          1'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
